// File: rtl/instruction_loader.sv
// Boot-time loader: byte stream -> little-endian 32-bit words -> instruction memory.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
module instruction_loader #(
    parameter int DEPTH       = 256,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic                   loadStart_i,
    input  logic                   byteValid_i,
    input  logic [7:0]             byteData_i,
    output logic                   byteReady_o,
    output logic                   memWriteEn_o,
    output logic [31:0]            memWriteAddr_o,
    output logic [31:0]            memWriteData_o,
    output logic                   processorHold_o,
    output logic                   loadDone_o,
    output logic                   loadError_o,
    output logic [COUNT_WIDTH-1:0] wordsWritten_o
);

    typedef enum logic [2:0] {
        IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERROR
`ifdef LOADER_CHECKSUM_EN
        , CHECK
`endif
    } state_e;

`ifdef LOADER_CHECKSUM_EN
    localparam state_e FIN_ST = CHECK;
`else
    localparam state_e FIN_ST = DONE;
`endif

    state_e                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] count_q;
    logic [COUNT_WIDTH-1:0] words_q;
    logic [1:0]             lane_q;
    logic [31:0]            word_q;
    logic [31:0]            addr_q, data_q;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]             ck_q;
`endif

    logic        accept;
    logic        start_ok;
    logic [15:0] hdr_w;
    logic        last_word;

    assign accept    = byteValid_i && byteReady_o;
    assign start_ok  = loadStart_i && (state_q == IDLE || state_q == DONE || state_q == ERROR);
    assign hdr_w     = {byteData_i, count_q[7:0]};
    assign last_word = (words_q + COUNT_WIDTH'(1)) == count_q;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE, ERROR: if (loadStart_i) state_d = LEN_LO;
            LEN_LO:            if (accept) state_d = LEN_HI;
            LEN_HI: if (accept) begin
                if (hdr_w == 16'd0)                     state_d = FIN_ST;
                else if ({16'd0, hdr_w} > 32'(DEPTH))   state_d = ERROR;
                else                                    state_d = DATA;
            end
            DATA:   if (accept && lane_q == 2'd3) state_d = WRITE;
            WRITE:  state_d = last_word ? FIN_ST : DATA;
`ifdef LOADER_CHECKSUM_EN
            CHECK:  if (accept) state_d = (byteData_i == ck_q) ? DONE : ERROR;
`endif
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        byteReady_o     = 1'b0;
        memWriteEn_o    = 1'b0;
        loadDone_o      = 1'b0;
        loadError_o     = 1'b0;
        processorHold_o = 1'b1;
        case (state_q)
            LEN_LO, LEN_HI, DATA: byteReady_o = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            CHECK:                byteReady_o = 1'b1;
`endif
            WRITE:                memWriteEn_o = 1'b1;
            DONE: begin
                loadDone_o      = 1'b1;
                processorHold_o = 1'b0;
            end
            ERROR:                loadError_o = 1'b1;
            default: ;
        endcase
    end

    // Address/data latch on the 4th byte so they are valid during WRITE and hold afterwards.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            count_q <= '0;
            words_q <= '0;
            lane_q  <= 2'd0;
            word_q  <= 32'd0;
            addr_q  <= 32'd0;
            data_q  <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
            ck_q    <= 8'd0;
`endif
        end else begin
            if (start_ok) begin
                words_q <= '0;
                lane_q  <= 2'd0;
`ifdef LOADER_CHECKSUM_EN
                ck_q    <= 8'd0;
`endif
            end
            case (state_q)
                LEN_LO: if (accept) count_q <= COUNT_WIDTH'(byteData_i);
                LEN_HI: if (accept) count_q <= COUNT_WIDTH'(hdr_w);
                DATA: if (accept) begin
                    lane_q <= lane_q + 2'd1;
                    word_q[{lane_q, 3'b000} +: 8] <= byteData_i;
`ifdef LOADER_CHECKSUM_EN
                    ck_q <= ck_q ^ byteData_i;
`endif
                    if (lane_q == 2'd3) begin
                        data_q <= {byteData_i, word_q[23:0]};
                        addr_q <= 32'(words_q) << 2;
                    end
                end
                WRITE: words_q <= words_q + COUNT_WIDTH'(1);
                default: ;
            endcase
        end
    end

    assign memWriteAddr_o = addr_q;
    assign memWriteData_o = data_q;
    assign wordsWritten_o = words_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Randomized bench for instruction_loader with a word-list reference model.
module tb_instruction_loader;
    localparam int DEPTH = 256;
    localparam int CW    = 16;

    logic          clk = 1'b0, rst = 1'b1, ls = 1'b0, bv = 1'b0;
    logic [7:0]    bd = 8'd0;
    logic          br, we, hold, done, err;
    logic [31:0]   wa, wd;
    logic [CW-1:0] ww;

    int          nvec = 0, nerr = 0;
    logic [7:0]  dat[$];
    logic [63:0] got[$];

    always #5 clk = ~clk;

    instruction_loader #(.DEPTH(DEPTH), .COUNT_WIDTH(CW)) dut (
        .clock_i(clk), .reset_i(rst), .loadStart_i(ls), .byteValid_i(bv), .byteData_i(bd),
        .byteReady_o(br), .memWriteEn_o(we), .memWriteAddr_o(wa), .memWriteData_o(wd),
        .processorHold_o(hold), .loadDone_o(done), .loadError_o(err), .wordsWritten_o(ww)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    always @(negedge clk) if (!rst && we) begin
        got.push_back({wa, wd});
        chk("ready_in_write", {63'd0, br}, 64'd0);
    end

    task automatic send(input logic [7:0] b, input int gapmax, input bit pls);
        int tries;
        int gap;
        gap = $urandom_range(0, gapmax);
        repeat (gap) begin @(negedge clk); bv = 1'b0; ls = 1'b0; end
        @(negedge clk); bv = 1'b1; bd = b; ls = pls; tries = 0;
        while (!br && tries < 40) begin @(negedge clk); ls = 1'b0; tries++; end
        if (tries >= 40) chk("send_timeout", 64'd1, 64'd0);
        @(posedge clk);
    endtask

    task automatic fill(input int n);
        dat.delete();
        for (int i = 0; i < n; i++) dat.push_back(8'($urandom));
    endtask

    task automatic run_load(input int cnt, input int gapmax, input bit ckbad);
        logic [7:0]  x;
        logic [31:0] w;
        int lat, explat, explen;
        bit exp_err;
        got.delete();
        @(negedge clk); bv = 1'b0; ls = 1'b1;
        send(cnt[7:0], gapmax, 1'b0);
        send(cnt[15:8], gapmax, 1'b0);
        x = 8'd0; exp_err = (cnt > DEPTH); explat = 1;
        if (!exp_err) begin
            for (int i = 0; i < 4 * cnt; i++) begin
                send(dat[i], gapmax, $urandom_range(0, 7) == 0);
                x = x ^ dat[i];
            end
`ifdef LOADER_CHECKSUM_EN
            send(x ^ {7'd0, ckbad}, gapmax, 1'b0);
            exp_err = ckbad;
`else
            if (cnt != 0) explat = 2;
`endif
        end
        lat = 0;
        do begin @(negedge clk); bv = 1'b0; ls = 1'b0; lat++; end
        while (!(done || err) && lat < 20);
        explen = (cnt > DEPTH) ? 0 : cnt;
        chk("latency", 64'(lat), 64'(explat));
        chk("done", {63'd0, done}, {63'd0, !exp_err});
        chk("error", {63'd0, err}, {63'd0, exp_err});
        chk("hold", {63'd0, hold}, {63'd0, exp_err});
        chk("ready_after", {63'd0, br}, 64'd0);
        chk("nwrites", 64'(got.size()), 64'(explen));
        chk("words", 64'(ww), 64'(explen));
        for (int i = 0; i < explen && i < got.size(); i++) begin
            w = {dat[4*i+3], dat[4*i+2], dat[4*i+1], dat[4*i]};
            chk("wr_addr", 64'(got[i][63:32]), 64'(i * 4));
            chk("wr_data", 64'(got[i][31:0]), 64'(w));
        end
    endtask

    initial begin
        int cnt;
        repeat (2) @(negedge clk);
        chk("rst_ready", {63'd0, br}, 64'd0);
        chk("rst_we", {63'd0, we}, 64'd0);
        chk("rst_addr", 64'(wa), 64'd0);
        chk("rst_data", 64'(wd), 64'd0);
        chk("rst_hold", {63'd0, hold}, 64'd1);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_err", {63'd0, err}, 64'd0);
        chk("rst_words", 64'(ww), 64'd0);
        rst = 1'b0;

        dat = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        run_load(2, 0, 1'b0);
        chk("two_word_last", 64'(wd), 64'hDDCCBBAA);

        dat = '{8'h78, 8'h56, 8'h34, 8'h12};
        run_load(1, 1, 1'b0);
        chk("bp_word", 64'(wd), 64'h12345678);

        run_load(257, 0, 1'b0);
        run_load(0, 0, 1'b0);
        fill(4 * DEPTH);
        run_load(DEPTH, 0, 1'b0);
        run_load(65535, 1, 1'b0);

`ifdef LOADER_CHECKSUM_EN
        dat = '{8'h01, 8'h02, 8'h04, 8'h08};
        run_load(1, 0, 1'b0);
        run_load(1, 0, 1'b1);
`endif

        for (int k = 0; k < 20; k++) begin
            cnt = ($urandom_range(0, 9) == 0) ? 257 + $urandom_range(0, 1000) : $urandom_range(0, 6);
            fill(4 * cnt);
            run_load(cnt, $urandom_range(0, 3), $urandom_range(0, 3) == 0);
        end

        // Abandon a load after two data bytes; reset must act without a clock edge.
        @(negedge clk); ls = 1'b1; bv = 1'b0;
        send(8'h01, 0, 1'b0); send(8'h00, 0, 1'b0);
        send(8'h5A, 0, 1'b0); send(8'hA5, 0, 1'b0);
        @(negedge clk); bv = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_ready", {63'd0, br}, 64'd0);
        chk("arst_addr", 64'(wa), 64'd0);
        chk("arst_data", 64'(wd), 64'd0);
        chk("arst_hold", {63'd0, hold}, 64'd1);
        chk("arst_words", 64'(ww), 64'd0);
        chk("arst_done", {63'd0, done}, 64'd0);
        @(negedge clk); rst = 1'b0;
        fill(4);
        run_load(1, 2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
